operand_fetch: RTL
==================

// Module: operand_fetch
// PURPOSE
//  Operand-fetch stage between instruction decode and the ALU. Takes an operand-address pair,
//  drives the two read ports of the dual-read/single-write word RAM, absorbs its 1-cycle read
//  latency, and presents both operands on a valid/ready handshake. Also carries the ALU
//  write-back onto the RAM write port and resolves same-cycle write/read hazards.
// PARAMETERS
//  WIDTH   8  data word width (bits)
//  AWIDTH  8  RAM word-address width (bits)
// PORTS
//  clk             in   1       single clock, all state on rising edge
//  rst             in   1       synchronous, active-high reset
//  req_valid       in   1       decode presents an operand request
//  req_ready       out  1       stage accepts request this cycle
//  req_addr_a      in   AWIDTH  operand A address
//  req_addr_b      in   AWIDTH  operand B address
//  op_valid        out  1       op_a/op_b valid
//  op_ready        in   1       ALU consumes operands
//  op_a, op_b      out  WIDTH   fetched operands
//  wb_address      in   AWIDTH  write-back address
//  wb_data         in   WIDTH   write-back data
//  wb_we           in   1       write-back enable
//  port_a_address  out  AWIDTH  to RAM read port A
//  port_a_out      in   WIDTH   RAM read data A (one cycle after address)
//  port_b_address  out  AWIDTH  to RAM read port B
//  port_b_out      in   WIDTH   RAM read data B
//  port_c_address  out  AWIDTH  to RAM write port (= wb_address, combinational)
//  port_c_data     out  WIDTH   = wb_data
//  port_c_we       out  1       = wb_we
// BEHAVIOUR
//  - Two stages: S1 (read in flight: s1_v, s1_addr_a/b, bypass flags) and OUT (op_valid, op_a/b).
//  - Reset: s1_v=0, op_valid=0, op_a=op_b=0, bypass flags=0; in-flight requests discarded.
//    req_ready=1 in the first cycle after reset.
//  - out_free = !op_valid | op_ready; s1_adv = s1_v & out_free; req_ready = !s1_v | out_free.
//  - Accept (req_valid & req_ready): S1 loads addresses; port_x_address = req_addr_x.
//    Otherwise port_x_address = s1_addr_x (stalled read is re-issued every cycle, so data
//    returned at advance always reflects the latest sampled address).
//  - s1_adv: OUT loads port_a_out/port_b_out (or bypass data), op_valid=1. Latency: request
//    accepted in cycle t -> op_valid in cycle t+2. Throughput 1/cycle when op_ready held high.
//  - op_valid & !op_ready: op_a/op_b frozen; later writes to those addresses NOT reflected
//    (snapshot semantics). S1 holds if occupied; req_ready=0 only when both stages full and stalled.
//  - op_ready with op_valid=0: ignored. s1_v=0 & accept & op_ready: OUT drains, S1 fills, no bubble.
//  - Write path: port_c_* pass-through, no added latency; write never blocked by fetch stalls.
//  - RAM read-during-write on same address returns OLD data (see CONFIGURATION).
//  - Addresses wrap nothing; full AWIDTH range valid, address 0 is an ordinary word.
// CONFIGURATION
//  OPERAND_FETCH_BYPASS_EN defined: in each cycle a read address is driven, if wb_we and
//   wb_address == that address, wb_data captured into S1 bypass register with flag set;
//   at advance OUT takes bypass data instead of port_x_out. A re-issue cycle without a
//   matching write clears the flag (RAM now holds new data). Per-port independent; A==B both bypass.
//  Not defined: OUT always takes raw port_x_out; same-cycle write/read hazard returns old data
//   and is the compiler/software's responsibility. No bypass registers synthesised.
// STRUCTURE
//  - Shared package/header operand_fetch_pkg: WIDTH/AWIDTH defaults, handshake-state localparams
//    (S1/OUT occupancy encodings) used by bench scoreboard.
//  - One sub-module: opf_bypass (address compare + capture register + flag + output mux),
//    instantiated twice (port A, port B); empty pass-through when macro undefined.
// TESTING
//  1 Reset: assert rst 2 cycles mid-stream -> op_valid=0, op_a=op_b=0, req_ready=1 next cycle.
//  2 Streaming: RAM[3]=0x11,RAM[7]=0x22; req (3,7) cycle t, op_ready=1 -> op_valid t+2, op_a=0x11, op_b=0x22;
//    back-to-back 4 requests -> 4 consecutive valid cycles.
//  3 Backpressure: op_ready=0 for 5 cycles with 3 requests offered -> 2 accepted, req_ready=0,
//    op_a/op_b stable; release -> remaining delivered in order, none lost/duplicated.
//  4 Hazard: wb_we=1 addr 5 data 0xAA same cycle as req (5,5) with RAM[5]=0x01 -> BYPASS_EN: op_a=op_b=0xAA;
//    without: op_a=op_b=0x01.
//  5 Stall re-read: request in S1 stalled, write 0x5C to its addr A two cycles later -> op_a=0x5C at advance.
//  6 Snapshot: op_valid held (op_ready=0), write 0x77 to op_a's address -> op_a unchanged.

Source files
------------

// File: rtl/operand_fetch_pkg.sv
// Shared defaults and stage-occupancy encodings for the operand-fetch stage.
// Bypass option: OPERAND_FETCH_BYPASS_EN.
package operand_fetch_pkg;

  localparam int WIDTH_DEF  = 8;
  localparam int AWIDTH_DEF = 8;

  // {OUT occupied, S1 occupied}
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'b00,
    OCC_S1    = 2'b01,
    OCC_OUT   = 2'b10,
    OCC_BOTH  = 2'b11
  } occ_e;

  function automatic occ_e occupancy(input logic s1_v, input logic op_v);
    return occ_e'({op_v, s1_v});
  endfunction

endpackage

// File: rtl/opf_bypass.sv
// Per-port write-to-read forwarding for one RAM read port.
// Active only when OPERAND_FETCH_BYPASS_EN is defined; otherwise a pass-through.
module opf_bypass
  import operand_fetch_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int AWIDTH = AWIDTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AWIDTH-1:0] rd_address,
  input  logic [AWIDTH-1:0] wb_address,
  input  logic [WIDTH-1:0]  wb_data,
  input  logic              wb_we,
  input  logic [WIDTH-1:0]  ram_out,
  output logic [WIDTH-1:0]  data
);

`ifdef OPERAND_FETCH_BYPASS_EN
  logic             hit;
  logic             hit_q;
  logic [WIDTH-1:0] hit_data_q;

  assign hit = wb_we && (wb_address == rd_address);

  // The flag tracks the read issued this cycle, so a re-issue without a
  // matching write clears it: the RAM already holds the newer word.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_q      <= 1'b0;
      hit_data_q <= '0;
    end else begin
      hit_q <= hit;
      if (hit) hit_data_q <= wb_data;
    end
  end

  always_comb data = hit_q ? hit_data_q : ram_out;
`else
  logic unused_inputs;
  assign unused_inputs = ^{clk, rst, rd_address, wb_address, wb_data, wb_we};
  always_comb data = ram_out;
`endif

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage: two-stage (S1 read in flight, OUT operands) valid/ready pipe
// in front of a dual-read RAM. Optional write bypass: OPERAND_FETCH_BYPASS_EN.
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int AWIDTH = AWIDTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [AWIDTH-1:0] req_addr_a,
  input  logic [AWIDTH-1:0] req_addr_b,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [WIDTH-1:0]  op_a,
  output logic [WIDTH-1:0]  op_b,
  input  logic [AWIDTH-1:0] wb_address,
  input  logic [WIDTH-1:0]  wb_data,
  input  logic              wb_we,
  output logic [AWIDTH-1:0] port_a_address,
  input  logic [WIDTH-1:0]  port_a_out,
  output logic [AWIDTH-1:0] port_b_address,
  input  logic [WIDTH-1:0]  port_b_out,
  output logic [AWIDTH-1:0] port_c_address,
  output logic [WIDTH-1:0]  port_c_data,
  output logic              port_c_we
);

  logic              s1_v;
  logic [AWIDTH-1:0] s1_addr_a, s1_addr_b;
  logic              out_free, s1_adv, accept;
  logic [WIDTH-1:0]  fetch_a, fetch_b;

  assign out_free  = !op_valid || op_ready;
  assign s1_adv    = s1_v && out_free;
  assign req_ready = !s1_v || out_free;
  assign accept    = req_valid && req_ready;

  // A stalled S1 re-issues its read every cycle so the word returned at
  // advance reflects all writes up to the previous cycle.
  always_comb begin
    port_a_address = accept ? req_addr_a : s1_addr_a;
    port_b_address = accept ? req_addr_b : s1_addr_b;
  end

  assign port_c_address = wb_address;
  assign port_c_data    = wb_data;
  assign port_c_we      = wb_we;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v      <= 1'b0;
      s1_addr_a <= '0;
      s1_addr_b <= '0;
    end else if (accept) begin
      s1_v      <= 1'b1;
      s1_addr_a <= req_addr_a;
      s1_addr_b <= req_addr_b;
    end else if (s1_adv) begin
      s1_v <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_valid <= 1'b0;
      op_a     <= '0;
      op_b     <= '0;
    end else if (s1_adv) begin
      op_valid <= 1'b1;
      op_a     <= fetch_a;
      op_b     <= fetch_b;
    end else if (op_valid && op_ready) begin
      op_valid <= 1'b0;
    end
  end

  opf_bypass #(.WIDTH(WIDTH), .AWIDTH(AWIDTH)) u_byp_a (
    .clk        (clk),
    .rst        (rst),
    .rd_address (port_a_address),
    .wb_address (wb_address),
    .wb_data    (wb_data),
    .wb_we      (wb_we),
    .ram_out    (port_a_out),
    .data       (fetch_a)
  );

  opf_bypass #(.WIDTH(WIDTH), .AWIDTH(AWIDTH)) u_byp_b (
    .clk        (clk),
    .rst        (rst),
    .rd_address (port_b_address),
    .wb_address (wb_address),
    .wb_data    (wb_data),
    .wb_we      (wb_we),
    .ram_out    (port_b_out),
    .data       (fetch_b)
  );

endmodule
